// File: rtl/tlx_sram_arb.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_CH masters.
// Optional `TLX_SRAM_ARB_PRIO0_EN gives channel 0 fixed priority.
module tlx_sram_arb #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 27,
  parameter int RD_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_CH-1:0]              REQ_VALID,
  output logic [NUM_CH-1:0]              REQ_READY,
  input  logic [NUM_CH-1:0]              REQ_WRITE,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic [NUM_CH-1:0]              RSP_VALID,
  input  logic [NUM_CH-1:0]              RSP_READY,
  output logic [NUM_CH-1:0]              RSP_WRITE,
  output logic [NUM_CH*DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                           SRAM_CEn,
  output logic                           SRAM_WEn,
  output logic [ADDR_WIDTH-1:0]          SRAM_ADDR,
  output logic [DATA_WIDTH-1:0]          SRAM_WDATA,
  output logic [DATA_WIDTH/8-1:0]        SRAM_WBEn,
  input  logic [DATA_WIDTH-1:0]          SRAM_RDATA
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LL = RD_LATENCY - 1;

  logic [NUM_CH-1:0]     busy;
  logic [NUM_CH-1:0]     rsp_v;
  logic [NUM_CH-1:0]     rsp_w;
  logic [NUM_CH-1:0]     rsp_hs;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     gnt;
  logic [DATA_WIDTH-1:0] rsp_d [NUM_CH];
  logic [CW-1:0]         ptr;
  logic [CW-1:0]         ptr_nxt;
  logic [CW-1:0]         gnt_idx;
  logic [CW-1:0]         cand;
  logic                  gnt_any;
  logic                  ptr_en;
  logic [RD_LATENCY-1:0] tv;
  logic [RD_LATENCY-1:0] tw;
  logic [CW-1:0]         tc [RD_LATENCY];

  assign rsp_hs = rsp_v & RSP_READY;
  assign elig   = REQ_VALID & (~busy | rsp_hs);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
`ifdef TLX_SRAM_ARB_PRIO0_EN
    if (elig[0]) gnt_any = 1'b1;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CW'((int'(ptr) + k) % NUM_CH);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // no grants while reset is held, so outputs show idle values
    if (RESET) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CW'(1);
`ifdef TLX_SRAM_ARB_PRIO0_EN
  assign ptr_en  = gnt_any && (gnt_idx != '0);
`else
  assign ptr_en  = gnt_any;
`endif

  assign REQ_READY = gnt;

  always_comb begin
    SRAM_CEn   = 1'b1;
    SRAM_WEn   = 1'b1;
    SRAM_WBEn  = '1;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;
    if (gnt_any) begin
      SRAM_CEn   = 1'b0;
      SRAM_WEn   = ~REQ_WRITE[gnt_idx];
      SRAM_ADDR  = REQ_ADDR[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      SRAM_WDATA = REQ_WDATA[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      if (REQ_WRITE[gnt_idx])
        SRAM_WBEn = ~REQ_WSTRB[int'(gnt_idx)*SW +: SW];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr  <= '0;
      busy <= '0;
      tv   <= '0;
      tw   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tc[i] <= '0;
    end else begin
      if (ptr_en) ptr <= ptr_nxt;
      busy  <= (busy & ~rsp_hs) | gnt;
      tv[0] <= gnt_any;
      tw[0] <= gnt_any & REQ_WRITE[gnt_idx];
      tc[0] <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tv[i] <= tv[i-1];
        tw[i] <= tw[i-1];
        tc[i] <= tc[i-1];
      end
    end
  end

  // last tag stage lines up with SRAM_RDATA of the tagged access
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rsp_v <= '0;
      rsp_w <= '0;
      for (int c = 0; c < NUM_CH; c++) rsp_d[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tv[LL] && tc[LL] == CW'(c)) begin
          rsp_v[c] <= 1'b1;
          rsp_w[c] <= tw[LL];
          rsp_d[c] <= tw[LL] ? '0 : SRAM_RDATA;
        end else if (rsp_hs[c]) begin
          rsp_v[c] <= 1'b0;
        end
      end
    end
  end

  assign RSP_VALID = rsp_v;
  assign RSP_WRITE = rsp_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rsp
    assign RSP_RDATA[g*DATA_WIDTH +: DATA_WIDTH] = rsp_d[g];
  end

endmodule

// File: tb/tb_tlx_sram_arb.sv
// Directed bench for tlx_sram_arb: three channels, read latency 1,
// behavioural byte-enabled SRAM model.
module tb_tlx_sram_arb;

  localparam int NCH = 3;
  localparam int DW  = 64;
  localparam int AW  = 27;
  localparam int SW  = DW / 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NCH-1:0]    REQ_VALID;
  logic [NCH-1:0]    REQ_READY;
  logic [NCH-1:0]    REQ_WRITE;
  logic [NCH*AW-1:0] REQ_ADDR;
  logic [NCH*DW-1:0] REQ_WDATA;
  logic [NCH*SW-1:0] REQ_WSTRB;
  logic [NCH-1:0]    RSP_VALID;
  logic [NCH-1:0]    RSP_READY;
  logic [NCH-1:0]    RSP_WRITE;
  logic [NCH*DW-1:0] RSP_RDATA;
  logic              SRAM_CEn;
  logic              SRAM_WEn;
  logic [AW-1:0]     SRAM_ADDR;
  logic [DW-1:0]     SRAM_WDATA;
  logic [SW-1:0]     SRAM_WBEn;
  logic [DW-1:0]     SRAM_RDATA;

  logic [DW-1:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  logic [2:0] rot_exp [6];
  logic [2:0] bp_exp  [10];
  logic [2:0] pr_exp  [8];

  tlx_sram_arb #(
    .NUM_CH(NCH), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .RD_LATENCY(1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_WRITE(RSP_WRITE), .RSP_RDATA(RSP_RDATA),
    .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WBEn(SRAM_WBEn), .SRAM_RDATA(SRAM_RDATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    SRAM_RDATA = '0;
  end

  always @(posedge CLK) begin
    if (!SRAM_CEn) begin
      if (!SRAM_WEn) begin
        for (int b = 0; b < SW; b++)
          if (!SRAM_WBEn[b])
            mem[SRAM_ADDR[7:0]][b*8 +: 8] <= SRAM_WDATA[b*8 +: 8];
      end else begin
        SRAM_RDATA <= mem[SRAM_ADDR[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic setreq(input int ch, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
    REQ_WRITE[ch]           = w;
    REQ_ADDR[ch*AW +: AW]   = a;
    REQ_WDATA[ch*DW +: DW]  = d;
    REQ_WSTRB[ch*SW +: SW]  = s;
  endtask

  initial begin
    rot_exp = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    bp_exp  = '{3'b010, 3'b001, 3'b000, 3'b001, 3'b000,
                3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
    pr_exp  = '{3'b001, 3'b100, 3'b001, 3'b010,
                3'b001, 3'b100, 3'b001, 3'b010};

    RESET     = 1'b1;
    REQ_VALID = 3'b011;
    REQ_WRITE = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    REQ_WSTRB = '0;
    RSP_READY = 3'b111;
    tick(); tick();
    #1;
    chk("rst_req_ready", 64'(REQ_READY), 64'h0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'h0);
    chk("rst_rsp_write", 64'(RSP_WRITE), 64'h0);
    chk("rst_rsp_rdata", 64'(|RSP_RDATA), 64'h0);
    chk("rst_cen", 64'(SRAM_CEn), 64'h1);
    chk("rst_wen", 64'(SRAM_WEn), 64'h1);
    chk("rst_wben", 64'(SRAM_WBEn), 64'hFF);
    chk("rst_addr", 64'(SRAM_ADDR), 64'h0);
    chk("rst_wdata", SRAM_WDATA, 64'h0);
    tick();
    REQ_VALID = '0;
    RESET = 1'b0;

    // full write then read on ch0
    tick();
    setreq(0, 1'b1, 27'h10, 64'h1122334455667788, 8'hFF);
    REQ_VALID = 3'b001;
    #1;
    chk("wr_ready", 64'(REQ_READY), 64'h1);
    chk("wr_cen", 64'(SRAM_CEn), 64'h0);
    chk("wr_wen", 64'(SRAM_WEn), 64'h0);
    chk("wr_addr", 64'(SRAM_ADDR), 64'h10);
    chk("wr_wdata", SRAM_WDATA, 64'h1122334455667788);
    chk("wr_wben", 64'(SRAM_WBEn), 64'h00);
    tick();
    REQ_VALID = '0;
    #1;
    chk("wr_rsp_early", 64'(RSP_VALID), 64'h0);
    tick();
    setreq(0, 1'b0, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b001;
    #1;
    chk("wr_ack_valid", 64'(RSP_VALID), 64'h1);
    chk("wr_ack_write", 64'(RSP_WRITE), 64'h1);
    chk("wr_ack_data", RSP_RDATA[63:0], 64'h0);
    chk("rd_regrant", 64'(REQ_READY), 64'h1);
    chk("rd_wen", 64'(SRAM_WEn), 64'h1);
    chk("rd_wben", 64'(SRAM_WBEn), 64'hFF);
    tick();
    REQ_VALID = '0;
    #1;
    chk("rd_rsp_early", 64'(RSP_VALID), 64'h0);
    tick();
    #1;
    chk("rd_valid", 64'(RSP_VALID), 64'h1);
    chk("rd_write", 64'(RSP_WRITE), 64'h0);
    chk("rd_data", RSP_RDATA[63:0], 64'h1122334455667788);

    // partial write on ch1
    tick();
    setreq(1, 1'b1, 27'h10, 64'hFFFFFFFFAAAAAAAA, 8'h0F);
    REQ_VALID = 3'b010;
    #1;
    chk("pw_ready", 64'(REQ_READY), 64'h2);
    chk("pw_wben", 64'(SRAM_WBEn), 64'hF0);
    tick();
    REQ_VALID = '0;
    tick();
    setreq(1, 1'b0, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b010;
    #1;
    chk("pw_ack", 64'(RSP_VALID), 64'h2);
    chk("pw_ack_write", 64'(RSP_WRITE), 64'h2);
    chk("pw_rd_ready", 64'(REQ_READY), 64'h2);
    tick();
    REQ_VALID = '0;
    tick();
    #1;
    chk("pw_rd_valid", 64'(RSP_VALID), 64'h2);
    chk("pw_rd_data", RSP_RDATA[127:64], 64'h11223344AAAAAAAA);

    // all-zero strobe write on ch0 leaves memory intact
    tick();
    setreq(0, 1'b1, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b001;
    #1;
    chk("zs_ready", 64'(REQ_READY), 64'h1);
    chk("zs_cen", 64'(SRAM_CEn), 64'h0);
    chk("zs_wen", 64'(SRAM_WEn), 64'h0);
    chk("zs_wben", 64'(SRAM_WBEn), 64'hFF);
    tick();
    REQ_VALID = '0;
    tick();
    setreq(0, 1'b0, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b001;
    #1;
    chk("zs_ack", 64'(RSP_VALID), 64'h1);
    chk("zs_ack_write", 64'(RSP_WRITE), 64'h1);
    tick();
    REQ_VALID = '0;
    tick();
    #1;
    chk("zs_rd_data", RSP_RDATA[63:0], 64'h11223344AAAAAAAA);

`ifndef TLX_SRAM_ARB_PRIO0_EN
    // rotation: ptr sits at 1 here
    setreq(0, 1'b0, 27'h10, 64'h0, 8'h00);
    setreq(1, 1'b0, 27'h10, 64'h0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      REQ_VALID = 3'b011;
      #1;
      chk($sformatf("rot_gnt%0d", i), 64'(REQ_READY), 64'(rot_exp[i]));
      chk($sformatf("rot_cen%0d", i), 64'(SRAM_CEn), 64'h0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      REQ_VALID = '0;
    end
    #1;
    chk("rot_drain", 64'(RSP_VALID), 64'h0);

    // backpressure on ch1
    RSP_READY = 3'b101;
    for (int i = 0; i < 10; i++) begin
      tick();
      REQ_VALID = 3'b011;
      #1;
      chk($sformatf("bp_gnt%0d", i), 64'(REQ_READY), 64'(bp_exp[i]));
      if (i >= 3) begin
        chk($sformatf("bp_v1_%0d", i), 64'(RSP_VALID[1]), 64'h1);
        chk($sformatf("bp_d1_%0d", i), RSP_RDATA[127:64],
            64'h11223344AAAAAAAA);
      end
    end
    tick();
    REQ_VALID = '0;
    RSP_READY = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("bp_drain", 64'(RSP_VALID), 64'h0);
`else
    // ch0 priority; ch1/ch2 share leftover slots
    for (int c = 0; c < NCH; c++) setreq(c, 1'b0, 27'h10, 64'h0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      REQ_VALID = 3'b111;
      #1;
      chk($sformatf("pr_gnt%0d", i), 64'(REQ_READY), 64'(pr_exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      REQ_VALID = '0;
    end
    #1;
    chk("pr_drain", 64'(RSP_VALID), 64'h0);
`endif

    // reset one cycle after a read grant
    tick();
    setreq(0, 1'b0, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b001;
    #1;
    chk("mr_gnt", 64'(REQ_READY), 64'h1);
    tick();
    RESET = 1'b1;
    REQ_VALID = 3'b011;
    #1;
    chk("mr_rsp", 64'(RSP_VALID), 64'h0);
    chk("mr_ready", 64'(REQ_READY), 64'h0);
    chk("mr_cen", 64'(SRAM_CEn), 64'h1);
    tick();
    REQ_VALID = '0;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk($sformatf("mr_quiet%0d", i), 64'(RSP_VALID), 64'h0);
    end
    tick();
    setreq(1, 1'b0, 27'h10, 64'h0, 8'h00);
    REQ_VALID = 3'b011;
    #1;
    chk("mr_first_gnt", 64'(REQ_READY), 64'h1);
    tick();
    #1;
    chk("mr_second_gnt", 64'(REQ_READY), 64'h2);
    tick();
    REQ_VALID = '0;
    #1;
    chk("mr_rsp0", 64'(RSP_VALID), 64'h1);
    chk("mr_data0", RSP_RDATA[63:0], 64'h11223344AAAAAAAA);
    tick();
    #1;
    chk("mr_rsp1", 64'(RSP_VALID), 64'h2);
    chk("mr_data1", RSP_RDATA[127:64], 64'h11223344AAAAAAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
